// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   fetch_entry_t    : one buffered instruction word together with its address
//   PC_STEP          : sequential fetch increment (one ARM word)
//   PCPLUS8_OFFSET   : R15 read offset relative to the instruction address
//   RESET_PC_DEFAULT : default first fetch address after reset
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] PCPLUS8_OFFSET   = 32'd8;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries between memory and decoder.
//   clk, reset : clock, synchronous active-high reset
//   i_push     : write i_entry at the tail (accepted when not full, or when a
//                pop frees the head in the same cycle)
//   i_pop      : drop the head entry (ignored when empty)
//   i_flush    : empty the queue; overrides push and pop
//   o_head     : head entry (contents meaningless while empty)
//   o_count    : occupancy, o_full / o_empty status
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  fetch_entry_t          i_entry,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output fetch_entry_t          o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while not empty.
    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_entry;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues sequential word
// reads, buffers returned words with their PC and hands them to the decoder
// in order. A redirect restarts fetch at a new address, flushes the buffer and
// marks every request still in flight as stale.
//   clk, reset             : clock, synchronous active-high reset
//   imem_req_*             : valid/ready read request, word address
//   imem_resp_*            : in-order read data return
//   redirect_valid/_pc     : one-cycle restart pulse and target address
//   instr_valid/_ready     : decoder handshake on the queue head
//   instr, instr_pc        : head word and its address
//   instr_pcplus8          : instr_pc + 8 (R15 read value)
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus8
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_live;      // issued requests whose data will be kept
    logic [CW-1:0] r_drop;      // issued requests whose data will be discarded

    logic [CW-1:0] w_q_count;
    logic          w_q_full;
    logic          w_q_empty;
    fetch_entry_t  w_q_head;
    fetch_entry_t  w_push_entry;
    logic [CW:0]   w_q_plus_live;
    logic [CW:0]   w_live_plus_drop;
    logic          w_hs;
    logic          w_resp_live;
    logic          w_resp_drop;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_resp_pc;

    // Only registered state feeds the request; ready never loops back into it.
    assign w_q_plus_live    = (CW+1)'(w_q_count) + (CW+1)'(r_live);
    assign w_live_plus_drop = (CW+1)'(r_live) + (CW+1)'(r_drop);
    assign imem_req_valid   = !reset && (w_q_plus_live < (CW+1)'(DEPTH))
                                     && (w_live_plus_drop < (CW+1)'(DEPTH));
    assign imem_req_addr    = r_fetch_pc;
    assign w_hs             = imem_req_valid && imem_req_ready;

    assign w_resp_drop = imem_resp_valid && (r_drop != '0);
    assign w_resp_live = imem_resp_valid && (r_drop == '0);

    // Live requests are consecutive words ending just below fetch_pc, so the
    // oldest one sits r_live words back (modulo 2^32).
    assign w_resp_pc = r_fetch_pc - (32'(r_live) << 2);

    assign w_push_entry.pc    = w_resp_pc;
    assign w_push_entry.instr = imem_resp_data;
    assign w_push             = w_resp_live && !redirect_valid;
    assign w_pop              = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_live     <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_live     <= '0;
            // Everything in flight becomes stale, including a request accepted
            // now; a response arriving now retires one of them.
            r_drop     <= r_drop + r_live + CW'(w_hs) - CW'(imem_resp_valid);
        end else begin
            if (w_hs) r_fetch_pc <= r_fetch_pc + PC_STEP;
            r_live <= r_live + CW'(w_hs) - CW'(w_resp_live);
            r_drop <= r_drop - CW'(w_resp_drop);
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_q_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign instr_valid   = !w_q_empty;
    assign instr         = instr_valid ? w_q_head.instr : 32'h0;
    assign instr_pc      = instr_valid ? w_q_head.pc    : 32'h0;
    assign instr_pcplus8 = instr_pc + PCPLUS8_OFFSET;

    logic w_unused;
    assign w_unused = w_q_full;

endmodule
